// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB latch, register-file commit with bypassed read ports,
// saturating retire counters and the RUN/HALTED state that stops the simulator.
module writeback_stage #(
    parameter int DATA       = 32,
    parameter int REG_COUNT  = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA-1:0]       mem_data,
    input  logic [DATA-1:0]       alu_data,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    input  logic                  reg_write,
    input  logic                  mem_to_reg,
    input  logic                  is_halt,
    input  logic [1:0]            instr_class,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic [DATA-1:0]       rs_data,
    output logic [DATA-1:0]       rt_data,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic [DATA-1:0]       wb_data,
    output logic                  wb_we,
    output logic                  halted,
    output logic [CNT_W-1:0]      cnt_arith,
    output logic [CNT_W-1:0]      cnt_logic,
    output logic [CNT_W-1:0]      cnt_mem,
    output logic [CNT_W-1:0]      cnt_ctrl,
    output logic [CNT_W-1:0]      cnt_total
);
    typedef enum logic {RUN, HALTED} state_t;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    state_t state, state_nxt;
    logic cap;
    logic [DATA-1:0] rf [REG_COUNT];
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + CNT_ONE;
    endfunction
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= RUN;
        else state <= state_nxt;
    always_comb state_nxt = (state == RUN && in_valid && is_halt) ? HALTED : state;
    always_comb begin
        halted = state == HALTED;
        cap    = in_valid && state == RUN;
    end
    // wb_reg/wb_data hold on bubbles so forwarding sees stable values
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_reg   <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= cap;
            wb_we    <= cap && reg_write && dest_reg != '0;
            if (cap) begin
                wb_reg  <= dest_reg;
                wb_data <= mem_to_reg ? mem_data : alu_data;
            end
        end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
        end else if (wb_we) begin
            rf[wb_reg] <= wb_data;
        end
    // bypass the latched result so decode never sees the stale entry during commit
    always_comb begin
        rs_data = rs_addr == '0 ? '0 : (wb_we && wb_reg == rs_addr) ? wb_data : rf[rs_addr];
        rt_data = rt_addr == '0 ? '0 : (wb_we && wb_reg == rt_addr) ? wb_data : rf[rt_addr];
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt_arith <= '0;
            cnt_logic <= '0;
            cnt_mem   <= '0;
            cnt_ctrl  <= '0;
            cnt_total <= '0;
        end else if (cap) begin
            cnt_total <= sat_inc(cnt_total);
            cnt_arith <= instr_class == 2'd0 ? sat_inc(cnt_arith) : cnt_arith;
            cnt_logic <= instr_class == 2'd1 ? sat_inc(cnt_logic) : cnt_logic;
            cnt_mem   <= instr_class == 2'd2 ? sat_inc(cnt_mem) : cnt_mem;
            cnt_ctrl  <= instr_class == 2'd3 ? sat_inc(cnt_ctrl) : cnt_ctrl;
        end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed table, HALT/reset/saturation sequences and a
// randomized run checked against an architectural-state model.
module tb_writeback_stage;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;
    logic clk = 1'b0, reset = 1'b0;
    logic in_valid = 1'b0, reg_write = 1'b0, mem_to_reg = 1'b0, is_halt = 1'b0;
    logic [31:0] mem_data = '0, alu_data = '0;
    logic [4:0] dest_reg = '0, rs_addr = '0, rt_addr = '0;
    logic [1:0] instr_class = '0;
    logic [31:0] rs_data, rt_data, wb_data;
    logic wb_valid, wb_we, halted;
    logic [4:0] wb_reg;
    logic [CW-1:0] cnt_arith, cnt_logic, cnt_mem, cnt_ctrl, cnt_total;
    int checks = 0, errors = 0;
    logic [31:0] arch [32];
    int mcnt [4];
    int mtotal;
    logic m_halted, m_valid, m_we;
    logic [4:0] m_reg;
    logic [31:0] m_data;
    writeback_stage #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mem_data(mem_data), .alu_data(alu_data),
        .dest_reg(dest_reg), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .is_halt(is_halt),
        .instr_class(instr_class), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
        .rt_data(rt_data), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_we(wb_we),
        .halted(halted), .cnt_arith(cnt_arith), .cnt_logic(cnt_logic), .cnt_mem(cnt_mem),
        .cnt_ctrl(cnt_ctrl), .cnt_total(cnt_total)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic v, rw, m2r;
        logic [31:0] mem, alu;
        logic [4:0] dest, rs, rt;
        logic [1:0] cls;
        logic [31:0] e_rs, e_rt, e_wbd;
        logic e_we;
    } vec_t;
    vec_t vec [6];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask
    task automatic model_clear();
        for (int i = 0; i < 32; i++) arch[i] = '0;
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        mtotal = 0; m_halted = 0; m_valid = 0; m_we = 0; m_reg = '0; m_data = '0;
    endtask
    task automatic model_edge();
        if (!m_halted && in_valid) begin
            m_valid = 1;
            m_reg = dest_reg;
            m_data = mem_to_reg ? mem_data : alu_data;
            m_we = reg_write && dest_reg != 0;
            if (m_we) arch[dest_reg] = m_data;
            mtotal = mtotal < CMAX ? mtotal + 1 : CMAX;
            mcnt[instr_class] = mcnt[instr_class] < CMAX ? mcnt[instr_class] + 1 : CMAX;
            if (is_halt) m_halted = 1;
        end else begin
            m_valid = 0;
            m_we = 0;
        end
    endtask
    task automatic check_all();
        chk("wb_valid", 32'(wb_valid), 32'(m_valid));
        chk("wb_we", 32'(wb_we), 32'(m_we));
        chk("wb_reg", 32'(wb_reg), 32'(m_reg));
        chk("wb_data", wb_data, m_data);
        chk("halted", 32'(halted), 32'(m_halted));
        chk("rs_data", rs_data, arch[rs_addr]);
        chk("rt_data", rt_data, arch[rt_addr]);
        chk("cnt_arith", 32'(cnt_arith), 32'(mcnt[0]));
        chk("cnt_logic", 32'(cnt_logic), 32'(mcnt[1]));
        chk("cnt_mem", 32'(cnt_mem), 32'(mcnt[2]));
        chk("cnt_ctrl", 32'(cnt_ctrl), 32'(mcnt[3]));
        chk("cnt_total", 32'(cnt_total), 32'(mtotal));
    endtask
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask
    task automatic do_reset();
        reset = 0; in_valid = 0; is_halt = 0;
        #1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask
    task automatic drive(input logic v, input logic [4:0] d, input logic [31:0] a, input logic [1:0] c, input logic h);
        in_valid = v; dest_reg = d; alu_data = a; instr_class = c; is_halt = h;
        reg_write = !h; mem_to_reg = 0;
    endtask
    initial begin
        vec[0] = '{1, 1, 0, 32'h0, 32'h1234_5678, 5, 5, 0, 0, 32'h1234_5678, 0, 32'h1234_5678, 1};
        vec[1] = '{0, 0, 0, 32'h0, 32'h0, 0, 5, 0, 0, 32'h1234_5678, 0, 32'h1234_5678, 0};
        vec[2] = '{1, 1, 1, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 2, 0, 0, 32'hDEAD_BEEF, 0};
        vec[3] = '{1, 1, 0, 32'h0, 32'h11, 7, 5, 7, 1, 32'h1234_5678, 32'h11, 32'h11, 1};
        vec[4] = '{1, 1, 0, 32'h0, 32'h22, 7, 5, 7, 1, 32'h1234_5678, 32'h22, 32'h22, 1};
        vec[5] = '{0, 0, 0, 32'h0, 32'h0, 0, 0, 7, 0, 0, 32'h22, 32'h22, 0};
        do_reset();
        rs_addr = 5; rt_addr = 7;
        check_all();
        chk("reset_wb_data", wb_data, 0);
        chk("reset_total", 32'(cnt_total), 0);
        for (int i = 0; i < 6; i++) begin
            in_valid = vec[i].v; reg_write = vec[i].rw; mem_to_reg = vec[i].m2r;
            mem_data = vec[i].mem; alu_data = vec[i].alu; dest_reg = vec[i].dest;
            rs_addr = vec[i].rs; rt_addr = vec[i].rt; instr_class = vec[i].cls; is_halt = 0;
            step();
            chk($sformatf("vec%0d_rs", i), rs_data, vec[i].e_rs);
            chk($sformatf("vec%0d_rt", i), rt_data, vec[i].e_rt);
            chk($sformatf("vec%0d_wbd", i), wb_data, vec[i].e_wbd);
            chk($sformatf("vec%0d_we", i), 32'(wb_we), 32'(vec[i].e_we));
            check_all();
        end
        chk("tbl_total", 32'(cnt_total), 4);
        chk("tbl_mem", 32'(cnt_mem), 1);
        chk("tbl_logic", 32'(cnt_logic), 2);
        // HALT: preceding write commits, later traffic ignored
        do_reset();
        rs_addr = 3; rt_addr = 0;
        drive(1, 3, 32'h5, 0, 0); step(); check_all();
        drive(1, 0, 32'h0, 3, 1); step(); check_all();
        chk("halt_halted", 32'(halted), 1);
        chk("halt_wb_valid", 32'(wb_valid), 1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 32'h99, 0, 0); step(); check_all();
            chk("halt_ignored_valid", 32'(wb_valid), 0);
            chk("halt_r3", rs_data, 32'h5);
        end
        chk("halt_ctrl", 32'(cnt_ctrl), 1);
        chk("halt_total", 32'(cnt_total), 2);
        // async reset with a commit pending
        do_reset();
        rs_addr = 9;
        drive(1, 9, 32'hAB, 0, 0); step();
        chk("pre_areset_we", 32'(wb_we), 1);
        #2 reset = 0;
        #1;
        chk("areset_we", 32'(wb_we), 0);
        chk("areset_valid", 32'(wb_valid), 0);
        chk("areset_wbd", wb_data, 0);
        chk("areset_total", 32'(cnt_total), 0);
        chk("areset_r9", rs_data, 0);
        model_clear();
        in_valid = 0;
        @(posedge clk);
        #1 reset = 1;
        step(); check_all();
        chk("areset_lost", rs_data, 0);
        // counter saturation
        do_reset();
        for (int i = 0; i < CMAX; i++) begin
            drive(1, 5'($urandom_range(0, 31)), $urandom, 0, 0); step();
        end
        chk("sat_arith_max", 32'(cnt_arith), CMAX);
        drive(1, 4, 32'h7, 0, 0); step();
        chk("sat_arith_hold", 32'(cnt_arith), CMAX);
        chk("sat_total_hold", 32'(cnt_total), CMAX);
        check_all();
        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in_valid = $urandom_range(0, 9) < 7;
            mem_data = $urandom; alu_data = $urandom;
            dest_reg = 5'($urandom_range(0, 31)); reg_write = $urandom_range(0, 3) != 0;
            mem_to_reg = 1'($urandom_range(0, 1)); instr_class = 2'($urandom_range(0, 3));
            is_halt = i > 400 && $urandom_range(0, 99) == 0;
            rs_addr = 5'($urandom_range(0, 31)); rt_addr = dest_reg;
            step();
            check_all();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final (WB) stage of the MIPS-Lite 5-stage pipeline, directly downstream of the memory-access stage. Captures each retiring instruction from MEM into a registered MEM/WB latch, selects load data or ALU result, commits it to the 32-entry register file one cycle later, and provides bypassed register-file read ports to decode. Also maintains per-class retired-instruction counters and the HALT state that stops the simulator.

## Interface
- DATA, 32, data/register width
- REG_COUNT, 32, number of architectural registers
- REG_ADDR_W, 5, register index width
- CNT_W, 32, width of each statistics counter
- clk  input  1  pipeline clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset; one clock domain only
- in_valid  input  1  MEM presents a retiring instruction this cycle
- mem_data  input  DATA  load data from memory-access stage
- alu_data  input  DATA  ALU/pass-through result from memory-access stage
- dest_reg  input  REG_ADDR_W  destination register index
- reg_write  input  1  instruction writes a register
- mem_to_reg  input  1  1 selects mem_data, 0 selects alu_data
- is_halt  input  1  instruction is HALT
- instr_class  input  2  0 arithmetic, 1 logical, 2 memory, 3 control-flow
- rs_addr, rt_addr  input  REG_ADDR_W  decode read indices
- rs_data, rt_data  output  DATA  combinational read data (bypassed)
- wb_valid  output  1  WB latch holds a valid instruction
- wb_reg  output  REG_ADDR_W  WB latch destination (for forwarding)
- wb_data  output  DATA  WB latch selected result (for forwarding)
- wb_we  output  1  WB latch will commit a register write
- halted  output  1  HALT has retired
- cnt_arith, cnt_logic, cnt_mem, cnt_ctrl, cnt_total  output  CNT_W  retired-instruction counters

## Operation
- State machine: RUN, HALTED. Reset → RUN. RUN → HALTED on the edge that captures in_valid && is_halt. HALTED is absorbing until reset.
- Capture (RUN only): on edge with in_valid=1, latch wb_valid=1, wb_reg=dest_reg, wb_data=(mem_to_reg ? mem_data : alu_data), wb_we=reg_write && dest_reg!=0. With in_valid=0, or in HALTED, wb_valid←0, wb_we←0 (wb_reg/wb_data hold).
- Commit: on every edge with wb_we=1, regfile[wb_reg]←wb_data. Commit of the latched instruction proceeds even on the edge entering or within HALTED.
- Register 0 is never written; reads of index 0 return 0.
- Read ports: rs_data = 0 if rs_addr==0; else wb_data if wb_we && wb_reg==rs_addr; else regfile[rs_addr]. Same for rt.
- Counters (RUN, on capture edge): cnt_total+1 and the counter selected by instr_class +1. HALT counts as its class and total. Writes to R0 still count. Counters saturate at all-ones, no wrap. No counting in HALTED.

## Timing
- Reset (reset=0, asynchronous, immediate): all regfile entries 0, all counters 0, wb_valid=0, wb_we=0, wb_reg=0, wb_data=0, halted=0, state RUN. Pending commit discarded.
- Latency: in_valid at edge E → wb_* valid after E → regfile updated at E+1; bypass covers the interval so reads see the value from just after E.
- Back-to-back writes to the same register: each commits in order; bypass always returns the youngest (latched) value.
- halted rises after the capture edge of HALT (same cycle wb_valid=1 for HALT).
- Reset deassertion: first capture on the first rising edge with reset=1.

## Test plan
- Reset then write: in_valid, reg_write, mem_to_reg=0, dest_reg=5, alu_data=0x1234_5678 → wb_data=0x12345678 next cycle, rs_addr=5 returns 0x12345678 via bypass then from regfile; cnt_total=1.
- Load select and R0: mem_to_reg=1, mem_data=0xDEAD_BEEF, dest_reg=0 → wb_we=0, rs_addr=0 reads 0; instruction still counted in its class.
- Back-to-back same register: writes 0x11 then 0x22 to R7 on consecutive cycles → rt_data(R7)=0x11 then 0x22, final regfile R7=0x22.
- HALT: ADD to R3 (0x5) followed by HALT (class 3), then further in_valid traffic → R3=0x5 committed, halted=1, cnt_ctrl=1, cnt_total=2, later inputs ignored.
- Async reset mid-operation: assert reset between edges while wb_we=1 → outputs and counters 0 immediately, pending write lost, register reads 0.
- Saturation: preload/force cnt_arith to all-ones, retire one arithmetic instruction → cnt_arith stays all-ones, cnt_total increments.
